main_control_fsm: RTL and testbench

//  Multicycle MIPS main control unit. Sequences each instruction through fetch, decode, execute, memory and writeback.

---
 rtl/main_control_fsm.sv | 134 +++++++++++++
 tb/tb_main_control_fsm.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/main_control_fsm.sv
// main_control_fsm: multicycle MIPS main control with memory-ready stalls and fetch counter
module main_control_fsm #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       Opcode,
    input  logic             MemReady,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             MemtoReg,
    output logic             IRWrite,
    output logic [1:0]       PCSource,
    output logic [1:0]       ALUOp,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic             RegWrite,
    output logic             RegDst,
    output logic             IllegalOp,
    output logic [3:0]       State,
    output logic [CNT_W-1:0] InstrCount
);
    localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100, OP_J = 6'b000010, OP_ADDI = 6'b001000;

    typedef enum logic [3:0] {
        FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMRD = 4'd3, MEMWB = 4'd4, MEMWR = 4'd5,
        EXEC = 4'd6, RWB = 4'd7, BRANCH = 4'd8, JUMP = 4'd9, ADDIEX = 4'd10, ADDIWB = 4'd11
    } state_e;

    state_e state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs are gated by rst_n so nothing strobes while reset is held
    always_comb begin
        state_d     = FETCH;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        MemtoReg    = 1'b0;
        IRWrite     = 1'b0;
        PCSource    = 2'b00;
        ALUOp       = 2'b00;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;
        IllegalOp   = 1'b0;
        if (rst_n) begin
            case (state_q)
                FETCH: begin
                    MemRead = 1'b1;
                    ALUSrcB = 2'b01;
                    IRWrite = MemReady;
                    PCWrite = MemReady;
                    state_d = MemReady ? DECODE : FETCH;
                end
                DECODE: begin
                    ALUSrcB   = 2'b11;
                    state_d   = (Opcode == OP_R) ? EXEC :
                                (Opcode == OP_LW || Opcode == OP_SW) ? MEMADR :
                                (Opcode == OP_BEQ) ? BRANCH :
                                (Opcode == OP_J) ? JUMP :
                                (Opcode == OP_ADDI) ? ADDIEX : FETCH;
                    IllegalOp = (state_d == FETCH);
                end
                MEMADR: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                    state_d = (Opcode == OP_LW) ? MEMRD : MEMWR;
                end
                MEMRD: begin
                    MemRead = 1'b1;
                    IorD    = 1'b1;
                    state_d = MemReady ? MEMWB : MEMRD;
                end
                MEMWB: begin
                    RegWrite = 1'b1;
                    MemtoReg = 1'b1;
                end
                MEMWR: begin
                    MemWrite = 1'b1;
                    IorD     = 1'b1;
                    state_d  = MemReady ? FETCH : MEMWR;
                end
                EXEC: begin
                    ALUSrcA = 1'b1;
                    ALUOp   = 2'b10;
                    state_d = RWB;
                end
                RWB: begin
                    RegWrite = 1'b1;
                    RegDst   = 1'b1;
                end
                BRANCH: begin
                    ALUSrcA     = 1'b1;
                    ALUOp       = 2'b01;
                    PCWriteCond = 1'b1;
                    PCSource    = 2'b01;
                end
                JUMP: begin
                    PCWrite  = 1'b1;
                    PCSource = 2'b10;
                end
                ADDIEX: begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = 2'b10;
                    state_d = ADDIWB;
                end
                ADDIWB: RegWrite = 1'b1;
                default: state_d = FETCH;
            endcase
        end
    end

    assign cnt_d      = cnt_q + {{(CNT_W-1){1'b0}}, IRWrite};
    assign State      = rst_n ? state_q : 4'd0;
    assign InstrCount = rst_n ? cnt_q : '0;
endmodule

// File: tb/tb_main_control_fsm.sv
// tb_main_control_fsm: directed-vector bench for main_control_fsm (CNT_W=4 to exercise wrap)
module tb_main_control_fsm;
    logic       clk = 1'b0, rst_n = 1'b0, MemReady = 1'b0;
    logic [5:0] Opcode = 6'd0;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite;
    logic [1:0] PCSource, ALUOp, ALUSrcB;
    logic       ALUSrcA, RegWrite, RegDst, IllegalOp;
    logic [3:0] State, InstrCount;
    int checks = 0, failures = 0;

    main_control_fsm #(.CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .Opcode(Opcode), .MemReady(MemReady),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .MemtoReg(MemtoReg), .IRWrite(IRWrite), .PCSource(PCSource),
        .ALUOp(ALUOp), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .RegWrite(RegWrite),
        .RegDst(RegDst), .IllegalOp(IllegalOp), .State(State), .InstrCount(InstrCount)
    );

    always #5 clk = ~clk;

    wire [16:0] outs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
                        PCSource, ALUOp, ALUSrcA, ALUSrcB, RegWrite, RegDst, IllegalOp};

    // Hand-written per-state output table
    function automatic logic [16:0] expo(input logic [3:0] s, input logic mr, input logic ill);
        logic pcw, pcwc, iord, mrd, mwr, m2r, irw, asa, rw, rd, il;
        logic [1:0] pcs, aop, asb;
        {pcw, pcwc, iord, mrd, mwr, m2r, irw, asa, rw, rd, il} = '0;
        {pcs, aop, asb} = '0;
        case (s)
            4'd0:  begin mrd = 1; asb = 2'b01; irw = mr; pcw = mr; end
            4'd1:  begin asb = 2'b11; il = ill; end
            4'd2:  begin asa = 1; asb = 2'b10; end
            4'd3:  begin mrd = 1; iord = 1; end
            4'd4:  begin rw = 1; m2r = 1; end
            4'd5:  begin mwr = 1; iord = 1; end
            4'd6:  begin asa = 1; aop = 2'b10; end
            4'd7:  begin rw = 1; rd = 1; end
            4'd8:  begin asa = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
            4'd9:  begin pcw = 1; pcs = 2'b10; end
            4'd10: begin asa = 1; asb = 2'b10; end
            4'd11: rw = 1;
            default: ;
        endcase
        return {pcw, pcwc, iord, mrd, mwr, m2r, irw, pcs, aop, asa, asb, rw, rd, il};
    endfunction

    task automatic drive(input logic mr, input logic [5:0] op);
        @(negedge clk);
        MemReady = mr;
        Opcode   = op;
        #1;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        MemReady = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        MemReady = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            checks++;
            if (outs !== 17'd0 || State !== 4'd0 || InstrCount !== 4'd0) begin
                failures++;
                $display("FAIL reset_hold cyc %0d: outs=%h state=%0d cnt=%0d, want 0/0/0", i, outs, State, InstrCount);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        MemReady = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (State !== 4'd0 || outs !== expo(4'd0, 1'b0, 1'b0) || InstrCount !== 4'd0) begin
                failures++;
                $display("FAIL reset_release cyc %0d: state=%0d outs=%h cnt=%0d, want 0/%h/0", i, State, outs, InstrCount, expo(4'd0, 1'b0, 1'b0));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_lw();
        int st[6] = '{0, 1, 2, 3, 4, 0};
        apply_reset();
        for (int i = 0; i < 6; i++) begin
            drive(i != 5, 6'b100011);
            checks++;
            if (State !== 4'(st[i]) || outs !== expo(4'(st[i]), i != 5, 1'b0)) begin
                failures++;
                $display("FAIL lw step %0d: state=%0d outs=%h, want %0d/%h", i, State, outs, st[i], expo(4'(st[i]), i != 5, 1'b0));
            end
        end
        checks++;
        if (InstrCount !== 4'd1) begin
            failures++;
            $display("FAIL lw_count: got %0d want 1", InstrCount);
        end
    endtask

    task automatic test_sw_stall();
        int   st[8] = '{0, 1, 2, 5, 5, 5, 5, 0};
        logic mr[8] = '{1, 0, 0, 0, 0, 0, 1, 0};
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            drive(mr[i], 6'b101011);
            checks++;
            if (State !== 4'(st[i]) || outs !== expo(4'(st[i]), mr[i], 1'b0)) begin
                failures++;
                $display("FAIL sw_stall step %0d: state=%0d outs=%h, want %0d/%h", i, State, outs, st[i], expo(4'(st[i]), mr[i], 1'b0));
            end
        end
        checks++;
        if (InstrCount !== 4'd1) begin
            failures++;
            $display("FAIL sw_count: got %0d want 1", InstrCount);
        end
    endtask

    task automatic test_beq_j_r_addi();
        int         st[15] = '{0, 1, 8, 0, 1, 9, 0, 1, 6, 7, 0, 1, 10, 11, 0};
        logic [5:0] op[15] = '{6'b000100, 6'b000100, 6'b000100, 6'b000010, 6'b000010, 6'b000010,
                               6'b000000, 6'b000000, 6'b000000, 6'b000000,
                               6'b001000, 6'b001000, 6'b001000, 6'b001000, 6'b001000};
        apply_reset();
        for (int i = 0; i < 15; i++) begin
            drive(i != 14, op[i]);
            checks++;
            if (State !== 4'(st[i]) || outs !== expo(4'(st[i]), i != 14, 1'b0)) begin
                failures++;
                $display("FAIL mix step %0d: state=%0d outs=%h, want %0d/%h", i, State, outs, st[i], expo(4'(st[i]), i != 14, 1'b0));
            end
            if (i == 10) begin
                checks++;
                if (InstrCount !== 4'd3) begin
                    failures++;
                    $display("FAIL mix_count3: got %0d want 3", InstrCount);
                end
            end
        end
        checks++;
        if (InstrCount !== 4'd4) begin
            failures++;
            $display("FAIL mix_count4: got %0d want 4", InstrCount);
        end
    endtask

    task automatic test_illegal();
        int st[3] = '{0, 1, 0};
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            drive(i != 2, 6'b111111);
            checks++;
            if (State !== 4'(st[i]) || outs !== expo(4'(st[i]), i != 2, i == 1)) begin
                failures++;
                $display("FAIL illegal step %0d: state=%0d outs=%h, want %0d/%h", i, State, outs, st[i], expo(4'(st[i]), i != 2, i == 1));
            end
        end
        checks++;
        if (InstrCount !== 4'd1) begin
            failures++;
            $display("FAIL illegal_count: got %0d want 1", InstrCount);
        end
    endtask

    task automatic test_wrap_and_async();
        apply_reset();
        for (int i = 1; i <= 17; i++) begin
            drive(1'b1, 6'b111111);
            drive(1'b1, 6'b111111);
            if (i >= 15) begin
                checks++;
                if (InstrCount !== 4'(i % 16)) begin
                    failures++;
                    $display("FAIL wrap after %0d fetches: got %0d want %0d", i, InstrCount, i % 16);
                end
            end
        end
        drive(1'b0, 6'b111111);
        drive(1'b1, 6'b100011);
        drive(1'b1, 6'b100011);
        drive(1'b1, 6'b100011);
        drive(1'b0, 6'b100011);
        checks++;
        if (State !== 4'd3) begin
            failures++;
            $display("FAIL async_pre: state=%0d want 3", State);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (State !== 4'd0 || outs !== 17'd0 || InstrCount !== 4'd0) begin
            failures++;
            $display("FAIL async_reset: state=%0d outs=%h cnt=%0d want 0/0/0", State, outs, InstrCount);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sw_stall();
        test_beq_j_r_addi();
        test_illegal();
        test_wrap_and_async();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
